// File: rtl/time_edit_pkg.sv
// -----------------------------------------------------------------------------
// time_edit_pkg
// Shared definitions for the BCD time-digit editor:
//   - DIGIT_W       : width of one BCD digit
//   - state_e       : editor FSM encoding (IDLE / EDIT / DONE)
//   - *_DIGIT_MAX   : packed per-digit upper limits for common time formats
//   - clamp_digit() : limits a loaded digit to its own maximum and to 9
// -----------------------------------------------------------------------------
package time_edit_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EDIT = 2'd1,
      DONE = 2'd2
   } state_e;

   // digit3..digit0 limits: MM:SS = 9,9,5,9 and HH:MM = 2,9,5,9
   localparam logic [15:0] MMSS_DIGIT_MAX = 16'h9959;
   localparam logic [15:0] HHMM_DIGIT_MAX = 16'h2959;

   // A digit limit above 9 is not a valid BCD bound, so 9 caps it as well.
   function automatic logic [DIGIT_W-1:0] clamp_digit(
      input logic [DIGIT_W-1:0] val,
      input logic [DIGIT_W-1:0] lim
   );
      logic [DIGIT_W-1:0] cap;
      cap = (lim > 4'd9) ? 4'd9 : lim;
      return (val > cap) ? cap : val;
   endfunction

endpackage

// File: rtl/time_digit_editor_btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
// Turns one debounced push-button level into single-cycle event pulses.
// Configuration macro: TIME_EDIT_AUTOREPEAT_EN (adds hold/repeat events).
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   level_i  : debounced button level
//   active_i : editor is in EDIT; events and repeat timing only run then
//   event_o  : one-cycle event pulse
// -----------------------------------------------------------------------------
module btn_event #(
   parameter bit REPEAT_EN     = 1'b0,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   input  logic active_i,
   output logic event_o
);

   logic prev_q;
   logic edge_s;

   // Button history, sampled every cycle regardless of editor state so a
   // button already held on EDIT entry does not look like a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_i;
      end
   end

   assign edge_s = level_i & ~prev_q & active_i;

`ifdef TIME_EDIT_AUTOREPEAT_EN
   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rep_q, rep_d;
   logic             rpt_s;

   // Hold/repeat timing: cnt counts cycles since the last event; rep marks
   // that the initial hold delay has already elapsed.
   always_comb begin
      cnt_d = cnt_q;
      rep_d = rep_q;
      rpt_s = 1'b0;
      if (REPEAT_EN && active_i && level_i && prev_q) begin
         if (!rep_q) begin
            if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
               rpt_s = 1'b1;
               cnt_d = CNT_W'(1);
               rep_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            if (cnt_q == CNT_W'(REPEAT_CYCLES)) begin
               rpt_s = 1'b1;
               cnt_d = CNT_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else if (edge_s) begin
         cnt_d = CNT_W'(1);
         rep_d = 1'b0;
      end else begin
         cnt_d = '0;
         rep_d = 1'b0;
      end
   end

   // Repeat timing registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end
   end

   assign event_o = edge_s | rpt_s;
`else
   // A repeating button with zero timing would be a configuration error;
   // such a button is kept inert so the mistake shows up immediately.
   localparam bit TIMING_OK = !REPEAT_EN || ((HOLD_CYCLES > 0) && (REPEAT_CYCLES > 0));

   assign event_o = edge_s & TIMING_OK;
`endif

endmodule

// File: rtl/time_digit_editor.sv
// -----------------------------------------------------------------------------
// time_digit_editor
// Cursor-based editor for an N-digit BCD value (digit 0 rightmost), each
// digit bounded by its own limit. edit_en enters/leaves EDIT; leaving emits
// a one-cycle done pulse. Configuration macro: TIME_EDIT_AUTOREPEAT_EN
// (up/down auto-repeat while held).
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   edit_en            : edit-mode level
//   push_u/d/l/r       : debounced button levels (up, down, left, right)
//   load, load_val     : preload strobe/value, honoured in IDLE only
//   sel                : one-hot cursor in EDIT, 0 otherwise
//   cursor             : cursor digit index
//   editing            : high while in EDIT
//   done               : one-cycle pulse after leaving EDIT
//   num                : edited BCD value
// -----------------------------------------------------------------------------
module time_digit_editor
   import time_edit_pkg::*;
#(
   parameter int                      NUM_DIGITS    = 4,
   parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX     = MMSS_DIGIT_MAX,
   parameter bit                      WRAP          = 1'b1,
   parameter int                      HOLD_CYCLES   = 25000000,
   parameter int                      REPEAT_CYCLES = 5000000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           edit_en,
   input  logic                           push_u,
   input  logic                           push_d,
   input  logic                           push_l,
   input  logic                           push_r,
   input  logic                           load,
   input  logic [4*NUM_DIGITS-1:0]        load_val,
   output logic [NUM_DIGITS-1:0]          sel,
   output logic [$clog2(NUM_DIGITS)-1:0]  cursor,
   output logic                           editing,
   output logic                           done,
   output logic [4*NUM_DIGITS-1:0]        num
);

   localparam int CUR_W = $clog2(NUM_DIGITS);
   localparam int NUM_W = DIGIT_W * NUM_DIGITS;

   state_e                 state_q, state_d;
   logic [CUR_W-1:0]       cursor_q, cursor_d;
   logic [NUM_W-1:0]       num_q, num_d;
   logic [NUM_DIGITS-1:0]  sel_q, sel_d;
   logic                   editing_q;
   logic                   done_q;

   logic                   in_edit_s;
   logic                   ev_u_s, ev_d_s, ev_l_s, ev_r_s;
   logic [DIGIT_W-1:0]     dig_s, lim_s, dig_new_s;

   assign in_edit_s = (state_q == EDIT);

   btn_event #(.REPEAT_EN(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
   u_btn_u (.clk(clk), .reset(reset), .level_i(push_u), .active_i(in_edit_s), .event_o(ev_u_s));

   btn_event #(.REPEAT_EN(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
   u_btn_d (.clk(clk), .reset(reset), .level_i(push_d), .active_i(in_edit_s), .event_o(ev_d_s));

   btn_event #(.REPEAT_EN(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
   u_btn_l (.clk(clk), .reset(reset), .level_i(push_l), .active_i(in_edit_s), .event_o(ev_l_s));

   btn_event #(.REPEAT_EN(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
   u_btn_r (.clk(clk), .reset(reset), .level_i(push_r), .active_i(in_edit_s), .event_o(ev_r_s));

   // New value of the digit under the (old) cursor; up beats down.
   always_comb begin
      dig_s     = num_q[cursor_q*DIGIT_W +: DIGIT_W];
      lim_s     = DIGIT_MAX[cursor_q*DIGIT_W +: DIGIT_W];
      dig_new_s = dig_s;
      if (ev_u_s) begin
         if (dig_s >= lim_s) begin
            dig_new_s = WRAP ? 4'd0 : dig_s;
         end else begin
            dig_new_s = dig_s + 4'd1;
         end
      end else if (ev_d_s) begin
         if (dig_s == 4'd0) begin
            dig_new_s = WRAP ? lim_s : dig_s;
         end else begin
            dig_new_s = dig_s - 4'd1;
         end
      end else begin
         dig_new_s = dig_s;
      end
   end

   // Next-state, value, cursor and cursor-mask logic.
   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      num_d    = num_q;
      sel_d    = '0;
      case (state_q)
         IDLE: begin
            if (load) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  num_d[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W],
                                                            DIGIT_MAX[i*DIGIT_W +: DIGIT_W]);
               end
            end else begin
               num_d = num_q;
            end
            if (edit_en) begin
               state_d  = EDIT;
               cursor_d = CUR_W'(NUM_DIGITS - 1);
            end else begin
               state_d  = IDLE;
            end
         end
         EDIT: begin
            if (!edit_en) begin
               // Exit cycle: no edit, no cursor move.
               state_d = DONE;
            end else begin
               num_d[cursor_q*DIGIT_W +: DIGIT_W] = dig_new_s;
               if (ev_l_s) begin
                  cursor_d = (cursor_q == CUR_W'(NUM_DIGITS - 1)) ? '0 : cursor_q + CUR_W'(1);
               end else if (ev_r_s) begin
                  cursor_d = (cursor_q == '0) ? CUR_W'(NUM_DIGITS - 1) : cursor_q - CUR_W'(1);
               end else begin
                  cursor_d = cursor_q;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_d == EDIT) begin
         sel_d = NUM_DIGITS'(1) << cursor_d;
      end else begin
         sel_d = '0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cursor_q  <= '0;
         num_q     <= '0;
         sel_q     <= '0;
         editing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cursor_q  <= cursor_d;
         num_q     <= num_d;
         sel_q     <= sel_d;
         editing_q <= (state_d == EDIT);
         done_q    <= (state_d == DONE);
      end
   end

   assign sel     = sel_q;
   assign cursor  = cursor_q;
   assign editing = editing_q;
   assign done    = done_q;
   assign num     = num_q;

endmodule

// File: tb/tb_time_digit_editor.sv
// -----------------------------------------------------------------------------
// tb_time_digit_editor
// Drives a wrapping and a saturating editor with the same stimulus and
// compares both against a digit-array reference model every cycle.
// -----------------------------------------------------------------------------
module tb_time_digit_editor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        edit_en = 1'b0;
   logic        pu = 1'b0, pd = 1'b0, pl = 1'b0, pr = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0000;

   logic [3:0]  sel_w, sel_s;
   logic [1:0]  cur_w, cur_s;
   logic        edt_w, edt_s, done_w, done_s;
   logic [15:0] num_w, num_s;

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   int dmax [4];
   int m_dig [2][4];
   int m_mode;          // 0 idle, 1 edit, 2 done
   int m_cur;
   bit m_done;
   bit m_prev [4];

   always #5 clk = ~clk;

   time_digit_editor #(.NUM_DIGITS(4), .DIGIT_MAX(16'h9959), .WRAP(1'b1)) dut_w (
      .clk(clk), .reset(reset), .edit_en(edit_en),
      .push_u(pu), .push_d(pd), .push_l(pl), .push_r(pr),
      .load(load), .load_val(load_val),
      .sel(sel_w), .cursor(cur_w), .editing(edt_w), .done(done_w), .num(num_w));

   time_digit_editor #(.NUM_DIGITS(4), .DIGIT_MAX(16'h9959), .WRAP(1'b0)) dut_s (
      .clk(clk), .reset(reset), .edit_en(edit_en),
      .push_u(pu), .push_d(pd), .push_l(pl), .push_r(pr),
      .load(load), .load_val(load_val),
      .sel(sel_s), .cursor(cur_s), .editing(edt_s), .done(done_s), .num(num_s));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_num(input int w);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(m_dig[w][i]);
      return r;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cur = 0; m_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_prev[i] = 1'b0;
         m_dig[0][i] = 0;
         m_dig[1][i] = 0;
      end
   endtask

   // One clock of the reference behaviour, using the inputs present at the edge.
   task automatic model_step();
      bit lv [4];
      bit ev [4];
      lv[0] = pu; lv[1] = pd; lv[2] = pl; lv[3] = pr;
      for (int i = 0; i < 4; i++) begin
         ev[i] = lv[i] && !m_prev[i];
         m_prev[i] = lv[i];
      end
      case (m_mode)
         0: begin
            m_done = 1'b0;
            if (load) begin
               for (int i = 0; i < 4; i++) begin
                  int v;
                  v = int'(load_val[4*i +: 4]);
                  m_dig[0][i] = imin(imin(v, dmax[i]), 9);
                  m_dig[1][i] = m_dig[0][i];
               end
            end
            if (edit_en) begin
               m_mode = 1;
               m_cur = 3;
            end
         end
         1: begin
            if (!edit_en) begin
               m_mode = 2;
               m_done = 1'b1;
            end else begin
               for (int w = 0; w < 2; w++) begin
                  int d;
                  d = m_dig[w][m_cur];
                  if (ev[0]) begin
                     if (d == dmax[m_cur]) d = (w == 0) ? 0 : d;
                     else d = d + 1;
                  end else if (ev[1]) begin
                     if (d == 0) d = (w == 0) ? dmax[m_cur] : 0;
                     else d = d - 1;
                  end
                  m_dig[w][m_cur] = d;
               end
               if (ev[2]) m_cur = (m_cur + 1) % 4;
               else if (ev[3]) m_cur = (m_cur + 3) % 4;
            end
         end
         default: begin
            m_mode = 0;
            m_done = 1'b0;
         end
      endcase
   endtask

   task automatic compare_all();
      logic [3:0] es;
      es = (m_mode == 1) ? (4'b0001 << m_cur) : 4'b0000;
      check_eq("num_wrap",   {16'h0, num_w}, {16'h0, exp_num(0)});
      check_eq("num_sat",    {16'h0, num_s}, {16'h0, exp_num(1)});
      check_eq("sel_wrap",   {28'h0, sel_w}, {28'h0, es});
      check_eq("sel_sat",    {28'h0, sel_s}, {28'h0, es});
      check_eq("cursor_wrap",{30'h0, cur_w}, 32'(m_cur));
      check_eq("cursor_sat", {30'h0, cur_s}, 32'(m_cur));
      check_eq("editing_wrap", {31'h0, edt_w}, {31'h0, (m_mode == 1)});
      check_eq("editing_sat",  {31'h0, edt_s}, {31'h0, (m_mode == 1)});
      check_eq("done_wrap",  {31'h0, done_w}, {31'h0, m_done});
      check_eq("done_sat",   {31'h0, done_s}, {31'h0, m_done});
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Press-and-release of one button: 0=u 1=d 2=l 3=r
   task automatic press(input int b);
      pu = (b == 0); pd = (b == 1); pl = (b == 2); pr = (b == 3);
      step();
      pu = 1'b0; pd = 1'b0; pl = 1'b0; pr = 1'b0;
      step();
   endtask

   initial begin
      dmax[0] = 9; dmax[1] = 5; dmax[2] = 9; dmax[3] = 9;
      do_reset();
      check_eq("reset_num", {16'h0, num_w}, 32'h0);

      // preload then enter edit
      load = 1'b1; load_val = 16'h1234;
      step();
      load = 1'b0;
      check_eq("load_1234", {16'h0, num_w}, 32'h1234);
      edit_en = 1'b1;
      step();
      check_eq("entry_sel", {28'h0, sel_w}, 32'h8);
      check_eq("entry_cursor", {30'h0, cur_w}, 32'd3);

      // cursor to digit1, three increments: wrap vs saturate
      press(3); press(3);
      press(0); press(0); press(0);
      check_eq("inc_wrap", {16'h0, num_w}, 32'h1204);
      check_eq("inc_sat",  {16'h0, num_s}, 32'h1254);
      press(1);
      check_eq("dec_wrap_0", {16'h0, num_w}, 32'h1254);

      // cursor wrap both ways
      press(3); press(3);
      check_eq("r_wrap_cursor", {30'h0, cur_w}, 32'd3);
      check_eq("r_wrap_sel", {28'h0, sel_w}, 32'h8);
      press(2);
      check_eq("l_wrap_cursor", {30'h0, cur_w}, 32'd0);

      // exit: one-cycle done
      edit_en = 1'b0;
      step();
      check_eq("done_pulse", {31'h0, done_w}, 32'd1);
      step();
      check_eq("done_single", {31'h0, done_w}, 32'd0);

      // push_u held through entry must not fire
      pu = 1'b1; step();
      edit_en = 1'b1; step(); step(); step();
      check_eq("held_entry", {16'h0, num_w}, {16'h0, exp_num(0)});
      pu = 1'b0; step();

      // u + l together at cursor 2
      press(3);
      pu = 1'b1; pl = 1'b1; step();
      pu = 1'b0; pl = 1'b0; step();
      check_eq("ul_cursor", {30'h0, cur_w}, 32'd3);

      // clamped load in IDLE
      edit_en = 1'b0; step(); step();
      load = 1'b1; load_val = 16'h9999; step();
      load = 1'b0;
      check_eq("load_clamp", {16'h0, num_w}, 32'h9959);
      load = 1'b1; load_val = 16'hFAF7; step();
      load = 1'b0;
      check_eq("load_bcd_clamp", {16'h0, num_s}, 32'h9957);

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end
         if ($urandom_range(0, 39) == 0) edit_en = ~edit_en;
         pu = ($urandom_range(0, 2) == 0);
         pd = ($urandom_range(0, 2) == 0);
         pl = ($urandom_range(0, 3) == 0);
         pr = ($urandom_range(0, 3) == 0);
         load = ($urandom_range(0, 7) == 0);
         load_val = 16'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
